// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every signal between the unified memory-port arbiter and the rest of
// the CPU: the fetch-stage request/response, the memory-stage request/response,
// the non-pipelined memory port, and the stall/busy status lines.
//
//   fetch side  : if_req, if_addr, if_kill (to arbiter); if_rdata, if_valid (from)
//   data side   : d_req, d_we, d_addr, d_wdata (to arbiter); d_rdata, d_valid (from)
//   memory port : m_en, m_we, m_addr, m_wdata (from arbiter); m_rdata (to arbiter)
//   status      : stall_if, stall_mem, busy (from arbiter)
//
// slave  : the arbiter's view.
// master : the surrounding pipeline + memory view.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;

    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    logic        stall_if;
    logic        stall_mem;
    logic        busy;

    modport slave (
        input  if_req, if_addr, if_kill,
        output if_rdata, if_valid,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_valid,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata,
        output stall_if, stall_mem, busy
    );

    modport master (
        output if_req, if_addr, if_kill,
        input  if_rdata, if_valid,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_valid,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata,
        input  stall_if, stall_mem, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified memory port between instruction fetch and the
// memory stage. One access is outstanding at a time. Data requests win the
// arbitration unless a pending fetch has already lost STARVE_MAX consecutive
// arbitrations, in which case the fetch is forced through. Each access issues
// exactly one m_en cycle; reads return data MEM_LAT cycles later, which is
// captured into the owner's registered rdata and followed by a one-cycle valid
// pulse. A fetch can be abandoned with if_kill: its memory read still runs to
// completion but if_valid is suppressed.
//
// Ports:
//   clk   : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (fetch, data, memory port, status)
//
// Parameters:
//   MEM_LAT    : memory read latency counted from the m_en cycle (1..15)
//   STARVE_MAX : lost arbitrations before a pending fetch is forced (1..15)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                clear,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        own_fetch, own_fetch_nxt;
    logic        we_q, we_nxt;
    logic [3:0]  lat_cnt, lat_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic        drop, drop_nxt;

    logic [31:0] addr_q, wdata_q;
    logic [31:0] if_rdata_q, d_rdata_q;

    logic        grant;
    logic        fetch_wins;
    logic        capture;
    logic        if_valid_int;
    logic        d_valid_int;

    // Fetch takes the port when it is alone, or when it has been starved long
    // enough; otherwise a pending data request wins.
    assign fetch_wins = bus.if_req && (!bus.d_req || (starve_cnt == STARVE_LIM));
    assign grant      = (state == IDLE) && (bus.if_req || bus.d_req);

    always_comb begin
        state_nxt     = state;
        own_fetch_nxt = own_fetch;
        we_nxt        = we_q;
        lat_nxt       = lat_cnt;
        starve_nxt    = starve_cnt;
        drop_nxt      = drop;
        capture       = 1'b0;

        unique case (state)
            IDLE: begin
                if (!bus.if_req) begin
                    starve_nxt = '0;
                end
                if (grant) begin
                    state_nxt     = ISSUE;
                    own_fetch_nxt = fetch_wins;
                    if (fetch_wins) begin
                        we_nxt     = 1'b0;
                        starve_nxt = '0;
                        // A kill landing on the granting cycle still lets the
                        // access run; only its response is thrown away.
                        drop_nxt   = bus.if_kill;
                    end else begin
                        we_nxt   = bus.d_we;
                        drop_nxt = 1'b0;
                        if (bus.if_req && (starve_cnt != STARVE_LIM)) begin
                            starve_nxt = starve_cnt + 4'd1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_nxt = RESP;
                end else begin
                    lat_nxt   = LAT_INIT;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                lat_nxt = lat_cnt - 4'd1;
                // lat_cnt == 1 marks cycle (m_en + MEM_LAT), when m_rdata is live.
                if (lat_cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if ((state != IDLE) && own_fetch && bus.if_kill) begin
            drop_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state      <= IDLE;
            own_fetch  <= 1'b0;
            we_q       <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            drop       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state      <= state_nxt;
            own_fetch  <= own_fetch_nxt;
            we_q       <= we_nxt;
            lat_cnt    <= lat_nxt;
            starve_cnt <= starve_nxt;
            drop       <= drop_nxt;
            if (capture) begin
                if (own_fetch) begin
                    if_rdata_q <= bus.m_rdata;
                end else begin
                    d_rdata_q <= bus.m_rdata;
                end
            end
        end
    end

    // Address/write-data latches are only observed while m_en is high, so
    // they need no reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            if (fetch_wins) begin
                addr_q  <= bus.if_addr;
                wdata_q <= '0;
            end else begin
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
            end
        end
    end

    // A kill arriving in the response cycle itself also suppresses the pulse.
    assign if_valid_int = (state == RESP) && own_fetch && !drop && !bus.if_kill;
    assign d_valid_int  = (state == RESP) && !own_fetch;

    assign bus.m_en     = (state == ISSUE);
    assign bus.m_we     = (state == ISSUE) && we_q;
    assign bus.m_addr   = (state == ISSUE) ? addr_q  : '0;
    assign bus.m_wdata  = (state == ISSUE) ? wdata_q : '0;

    assign bus.if_valid = if_valid_int;
    assign bus.d_valid  = d_valid_int;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.busy     = (state != IDLE);

    // Stalls are gated by clear so that every output reads 0 while reset is held.
    assign bus.stall_if  = clear && bus.if_req && !if_valid_int && !bus.if_kill;
    assign bus.stall_mem = clear && bus.d_req && !d_valid_int;

endmodule
